move_applier: RTL and testbench

Consumer of the 16-bit formatted move word. Accepts one move per valid/ready handshake, reads the source, destination and (for castling) rook squares from the board store, checks the move is consistent with the board, then writes the updated squares back. It maintains the side-to-move `turn`, reports any captured piece, and sits between move selection and the board register file.

---
 rtl/move_applier_pkg.sv | 53 +++++
 rtl/move_applier_if.sv | 25 ++
 rtl/move_applier_piece_pack.sv | 12 +
 rtl/move_applier.sv | 227 ++++++++++++++++++++++
 tb/tb_move_applier.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/move_applier_pkg.sv
// Shared encodings for the move applier: piece/move field layout, piece type
// codes, colours and the FSM state type.
package move_applier_pkg;

    // Move word bit indices and 3-bit field offsets.
    localparam int MV_INVALID = 15;
    localparam int MV_CASTLE  = 14;
    localparam int MV_PROMO   = 13;
    localparam int MV_CAPTURE = 12;
    localparam int MV_SRC_COL = 9;
    localparam int MV_SRC_ROW = 6;
    localparam int MV_DST_COL = 3;
    localparam int MV_DST_ROW = 0;

    localparam logic WHITE = 1'b0;
    localparam logic BLACK = 1'b1;

    typedef enum logic [2:0] {
        EMPTY   = 3'd0,
        PAWN    = 3'd1,
        KNIGHT  = 3'd2,
        BISHOP  = 3'd3,
        ROOK    = 3'd4,
        QUEEN   = 3'd5,
        KING    = 3'd6,
        INVALID = 3'd7
    } piece_type_t;

    typedef struct packed {
        piece_type_t ptype;
        logic [2:0]  col;
        logic [2:0]  row;
        logic        color;
    } piece_t;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_RD_SRC  = 4'd1,
        ST_RD_DST  = 4'd2,
        ST_RD_ROOK = 4'd3,
        ST_CHECK   = 4'd4,
        ST_WR_DST  = 4'd5,
        ST_WR_SRC  = 4'd6,
        ST_WR_RDST = 4'd7,
        ST_WR_RSRC = 4'd8,
        ST_DONE    = 4'd9
    } state_t;

    function automatic logic [5:0] sq_addr(input logic [2:0] col, input logic [2:0] row);
        return {col, row};
    endfunction

endpackage

// File: rtl/move_applier_if.sv
// Move handshake plus board-store port between move selection, the applier
// and the board register file.
interface move_applier_if;
    // A move transfers on a rising clk edge where move_valid && move_ready;
    // move must be stable while move_valid is high. brd_rd_data answers a
    // brd_rd_en strobe one cycle later; brd_wr_en writes at the same edge.
    logic        move_valid;
    logic [15:0] move;
    logic        move_ready;
    logic [5:0]  brd_addr;
    logic        brd_rd_en;
    logic [9:0]  brd_rd_data;
    logic        brd_wr_en;
    logic [9:0]  brd_wr_data;

    modport master (
        output move_valid, move, brd_rd_data,
        input  move_ready, brd_addr, brd_rd_en, brd_wr_en, brd_wr_data
    );

    modport slave (
        input  move_valid, move, brd_rd_data,
        output move_ready, brd_addr, brd_rd_en, brd_wr_en, brd_wr_data
    );
endinterface

// File: rtl/move_applier_piece_pack.sv
// Combinational builder of a {type,col,row,color} piece word.
module move_applier_piece_pack
    import move_applier_pkg::*;
(
    input  piece_type_t i_type,
    input  logic [2:0]  i_col,
    input  logic [2:0]  i_row,
    input  logic        i_color,
    output piece_t      o_piece
);
    assign o_piece = '{ptype: i_type, col: i_col, row: i_row, color: i_color};
endmodule

// File: rtl/move_applier.sv
// Applies one formatted move to the board store: reads the squares involved,
// validates against the board and side to move, then writes the result back.
module move_applier
    import move_applier_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    move_applier_if.slave bus,
    output logic          turn,
    output logic          done,
    output logic          error,
    output logic          cap_valid,
    output logic [9:0]    cap_piece,
    output state_t        o_dbg_state
);

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_mv;
    piece_type_t r_src_type;
    logic        r_src_color;
    piece_t      r_dst;
    logic        r_turn;
    logic        r_done;
    logic        r_error;
    logic        r_cap_valid;
    logic [9:0]  r_cap_piece;
    logic [9:0]  r_wr_data;

    logic        w_castle, w_promo, w_capture, w_invalid;
    logic [2:0]  w_src_col, w_src_row, w_dst_col, w_dst_row;
    logic        w_rook_right;
    logic [2:0]  w_rook_col, w_rook_dst;
    piece_t      w_rd_piece, w_check_dst, w_cap_latch;
    logic        w_dst_empty, w_err, w_done_err, w_to_done;
    logic        w_rd_en, w_wr_en;
    logic [5:0]  w_addr;
    piece_type_t w_pk_type;
    logic [2:0]  w_pk_col, w_pk_row;
    logic        w_pk_color;
    piece_t      w_pk_piece;

    assign w_invalid = r_mv[MV_INVALID];
    assign w_castle  = r_mv[MV_CASTLE];
    assign w_promo   = r_mv[MV_PROMO];
    assign w_capture = r_mv[MV_CAPTURE];
    assign w_src_col = r_mv[MV_SRC_COL +: 3];
    assign w_src_row = r_mv[MV_SRC_ROW +: 3];
    assign w_dst_col = r_mv[MV_DST_COL +: 3];
    assign w_dst_row = r_mv[MV_DST_ROW +: 3];

    // Rook sits on the far file in the direction the king travels.
    assign w_rook_right = (w_dst_col > w_src_col);
    assign w_rook_col   = w_rook_right ? 3'd7 : 3'd0;
    assign w_rook_dst   = w_rook_right ? (w_dst_col - 3'd1) : (w_dst_col + 3'd1);

    // In CHECK the read port holds the destination (normal) or the rook (castle).
    assign w_rd_piece  = piece_t'(bus.brd_rd_data);
    assign w_check_dst = w_castle ? r_dst : w_rd_piece;
    assign w_dst_empty = (w_check_dst.ptype == EMPTY);

    always_comb begin
        w_err = 1'b0;
        if (w_invalid)                                         w_err = 1'b1;
        if (r_src_type == EMPTY || r_src_type == INVALID)      w_err = 1'b1;
        if (r_src_color != r_turn)                             w_err = 1'b1;
        if (w_check_dst.ptype == INVALID)                      w_err = 1'b1;
        if (w_capture && w_dst_empty)                          w_err = 1'b1;
        if (!w_capture && !w_dst_empty)                        w_err = 1'b1;
        if (!w_dst_empty && w_check_dst.color == r_src_color)  w_err = 1'b1;
        if (w_castle && r_src_type != KING)                    w_err = 1'b1;
        if (w_castle && (w_rd_piece.ptype != ROOK || w_rd_piece.color != r_turn))
            w_err = 1'b1;
        if (w_castle && w_capture)                             w_err = 1'b1;
    end

    // Only CHECK can route to DONE with an error; write paths are error-free.
    assign w_done_err  = (r_state == ST_CHECK) && w_err;
    assign w_to_done   = (w_state_next == ST_DONE);
    assign w_cap_latch = (r_state == ST_CHECK) ? w_check_dst : r_dst;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_rd_en      = 1'b0;
        w_wr_en      = 1'b0;
        w_addr       = 6'd0;
        case (r_state)
            ST_IDLE: begin
                if (bus.move_valid) w_state_next = ST_RD_SRC;
            end
            ST_RD_SRC: begin
                w_rd_en      = 1'b1;
                w_addr       = sq_addr(w_src_col, w_src_row);
                w_state_next = ST_RD_DST;
            end
            ST_RD_DST: begin
                w_rd_en      = 1'b1;
                w_addr       = sq_addr(w_dst_col, w_dst_row);
                w_state_next = w_castle ? ST_RD_ROOK : ST_CHECK;
            end
            ST_RD_ROOK: begin
                w_rd_en      = 1'b1;
                w_addr       = sq_addr(w_rook_col, w_src_row);
                w_state_next = ST_CHECK;
            end
            ST_CHECK: begin
                w_state_next = w_err ? ST_DONE : ST_WR_DST;
            end
            ST_WR_DST: begin
                w_wr_en      = 1'b1;
                w_addr       = sq_addr(w_dst_col, w_dst_row);
                w_state_next = ST_WR_SRC;
            end
            ST_WR_SRC: begin
                w_wr_en      = 1'b1;
                w_addr       = sq_addr(w_src_col, w_src_row);
                w_state_next = w_castle ? ST_WR_RDST : ST_DONE;
            end
            ST_WR_RDST: begin
                w_wr_en      = 1'b1;
                w_addr       = sq_addr(w_rook_dst, w_src_row);
                w_state_next = ST_WR_RSRC;
            end
            ST_WR_RSRC: begin
                w_wr_en      = 1'b1;
                w_addr       = sq_addr(w_rook_col, w_src_row);
                w_state_next = ST_DONE;
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Write data is prepared one state ahead so it is registered when used.
    always_comb begin
        w_pk_type  = EMPTY;
        w_pk_col   = 3'd0;
        w_pk_row   = 3'd0;
        w_pk_color = 1'b0;
        case (w_state_next)
            ST_WR_DST: begin
                w_pk_type  = w_promo ? QUEEN : r_src_type;
                w_pk_col   = w_dst_col;
                w_pk_row   = w_dst_row;
                w_pk_color = r_src_color;
            end
            ST_WR_SRC: begin
                w_pk_col = w_src_col;
                w_pk_row = w_src_row;
            end
            ST_WR_RDST: begin
                w_pk_type  = ROOK;
                w_pk_col   = w_rook_dst;
                w_pk_row   = w_src_row;
                w_pk_color = r_turn;
            end
            ST_WR_RSRC: begin
                w_pk_col = w_rook_col;
                w_pk_row = w_src_row;
            end
            default: begin
                w_pk_type = EMPTY;
            end
        endcase
    end

    move_applier_piece_pack u_pack (
        .i_type  (w_pk_type),
        .i_col   (w_pk_col),
        .i_row   (w_pk_row),
        .i_color (w_pk_color),
        .o_piece (w_pk_piece)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mv        <= 16'd0;
            r_src_type  <= EMPTY;
            r_src_color <= 1'b0;
            r_dst       <= '0;
            r_turn      <= WHITE;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_cap_valid <= 1'b0;
            r_cap_piece <= 10'd0;
            r_wr_data   <= 10'd0;
        end else begin
            if (r_state == ST_IDLE && bus.move_valid) r_mv <= bus.move;
            if (r_state == ST_RD_DST) begin
                r_src_type  <= w_rd_piece.ptype;
                r_src_color <= w_rd_piece.color;
            end
            if (r_state == ST_RD_ROOK || (r_state == ST_CHECK && !w_castle))
                r_dst <= w_rd_piece;
            r_wr_data   <= w_pk_piece;
            r_done      <= w_to_done;
            r_error     <= w_to_done && w_done_err;
            r_cap_valid <= w_to_done && w_capture && !w_done_err;
            if (w_to_done) begin
                r_cap_piece <= w_cap_latch;
                if (!w_done_err) r_turn <= ~r_turn;
            end
        end
    end

    assign bus.move_ready  = (r_state == ST_IDLE);
    assign bus.brd_addr    = w_addr;
    assign bus.brd_rd_en   = w_rd_en;
    assign bus.brd_wr_en   = w_wr_en;
    assign bus.brd_wr_data = r_wr_data;
    assign turn            = r_turn;
    assign done            = r_done;
    assign error           = r_error;
    assign cap_valid       = r_cap_valid;
    assign cap_piece       = r_cap_piece;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_move_applier.sv
// Bench for move_applier: board-store model, rule-level reference model with
// expectation queues, and a negedge monitor that scores reads, writes and done.
module tb_move_applier;
    import move_applier_pkg::*;

    typedef struct packed {
        logic       err;
        logic       capv;
        logic [9:0] cap;
        logic       turn;
        logic [3:0] lat;
    } done_exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       turn, done, error, cap_valid;
    logic [9:0] cap_piece;
    state_t     dbg_state;

    move_applier_if bus();

    move_applier dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .turn        (turn),
        .done        (done),
        .error       (error),
        .cap_valid   (cap_valid),
        .cap_piece   (cap_piece),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- board store model ----------------
    logic [9:0] mem [64];
    logic [9:0] init_board [64];
    logic       load_req;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_board[i];
        end else if (bus.brd_wr_en) begin
            mem[bus.brd_addr] <= bus.brd_wr_data;
        end
        if (bus.brd_rd_en) bus.brd_rd_data <= mem[bus.brd_addr];
    end

    // ---------------- scoreboard state ----------------
    logic [9:0]  ref_board [64];
    logic        ref_turn;
    logic [5:0]  exp_rd_q [$];
    logic [15:0] exp_wr_q [$];
    done_exp_t   exp_done_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          done_seen = 0;
    logic        mon_en = 1'b0;
    logic        prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        done_exp_t e;
        if (mon_en) begin
            check("rd_wr_exclusive", 32'(bus.brd_rd_en & bus.brd_wr_en), 32'd0);
            if (bus.brd_rd_en) begin
                if (exp_rd_q.size() == 0) check("unexpected_read", 32'(bus.brd_addr), 32'hFFFF);
                else check("rd_addr", 32'(bus.brd_addr), 32'(exp_rd_q.pop_front()));
            end
            if (bus.brd_wr_en) begin
                if (exp_wr_q.size() == 0) check("unexpected_write", 32'({bus.brd_addr, bus.brd_wr_data}), 32'hFFFFF);
                else check("wr_addr_data", 32'({bus.brd_addr, bus.brd_wr_data}), 32'(exp_wr_q.pop_front()));
            end
            if (done) begin
                if (exp_done_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_done_q.pop_front();
                    check("done_latency", 32'(cyc - acc_cyc), 32'(e.lat));
                    check("done_error", 32'(error), 32'(e.err));
                    check("done_cap_valid", 32'(cap_valid), 32'(e.capv));
                    check("done_cap_piece", 32'(cap_piece), 32'(e.cap));
                    check("done_turn", 32'(turn), 32'(e.turn));
                    check("writes_left_at_done", 32'(exp_wr_q.size()), 32'd0);
                end
                done_seen++;
            end
            if (prev_done) check("ready_after_done", 32'(bus.move_ready), 32'd1);
            prev_done = done;
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [9:0] mk(input piece_type_t t, input int col, input int row, input logic color);
        return {t, 3'(col), 3'(row), color};
    endfunction

    function automatic logic [15:0] mkmv(input bit inv, input bit castle, input bit promo,
                                         input bit cap, input int sc, input int sr,
                                         input int dc, input int dr);
        return {inv, castle, promo, cap, 3'(sc), 3'(sr), 3'(dc), 3'(dr)};
    endfunction

    task automatic clear_board();
        for (int i = 0; i < 64; i++) init_board[i] = mk(EMPTY, i / 8, i % 8, 1'b0);
    endtask

    task automatic put(input int col, input int row, input piece_type_t t, input logic color);
        init_board[col * 8 + row] = mk(t, col, row, color);
    endtask

    task automatic start_position();
        piece_type_t back [8];
        back = '{ROOK, KNIGHT, BISHOP, QUEEN, KING, BISHOP, KNIGHT, ROOK};
        clear_board();
        for (int c = 0; c < 8; c++) begin
            put(c, 0, back[c], WHITE);
            put(c, 1, PAWN, WHITE);
            put(c, 6, PAWN, BLACK);
            put(c, 7, back[c], BLACK);
        end
    endtask

    task automatic random_board();
        int r;
        for (int i = 0; i < 64; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      init_board[i] = mk(EMPTY, i / 8, i % 8, 1'b0);
            else if (r < 97) init_board[i] = mk(piece_type_t'($urandom_range(1, 6)), i / 8, i % 8, 1'($urandom_range(0, 1)));
            else             init_board[i] = mk(INVALID, i / 8, i % 8, 1'($urandom_range(0, 1)));
        end
    endtask

    // Called only while the DUT is idle, at a negedge.
    task automatic load_board();
        for (int i = 0; i < 64; i++) ref_board[i] = init_board[i];
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // Reference model: applies the move rules to ref_board/ref_turn and queues
    // every read, write and done result the DUT should produce.
    task automatic model_move(input logic [15:0] mv);
        int sc, sr, dc, dr, rc, rdc;
        bit castle, promo, cap, bad;
        piece_t src, dst, rook;
        done_exp_t e;
        castle = mv[14]; promo = mv[13]; cap = mv[12];
        sc = int'(mv[11:9]); sr = int'(mv[8:6]); dc = int'(mv[5:3]); dr = int'(mv[2:0]);
        src = piece_t'(ref_board[sc * 8 + sr]);
        dst = piece_t'(ref_board[dc * 8 + dr]);
        rook = '0;
        rc = 0; rdc = 0;
        exp_rd_q.push_back(6'(sc * 8 + sr));
        exp_rd_q.push_back(6'(dc * 8 + dr));
        if (castle) begin
            rc  = (dc > sc) ? 7 : 0;
            rdc = (dc > sc) ? dc - 1 : dc + 1;
            rook = piece_t'(ref_board[rc * 8 + sr]);
            exp_rd_q.push_back(6'(rc * 8 + sr));
        end
        bad = mv[15];
        if (src.ptype == EMPTY || src.ptype == INVALID) bad = 1;
        if (src.color != ref_turn) bad = 1;
        if (dst.ptype == INVALID) bad = 1;
        if (cap && dst.ptype == EMPTY) bad = 1;
        if (!cap && dst.ptype != EMPTY) bad = 1;
        if (dst.ptype != EMPTY && dst.color == src.color) bad = 1;
        if (castle && src.ptype != KING) bad = 1;
        if (castle && !(rook.ptype == ROOK && rook.color == ref_turn)) bad = 1;
        if (castle && cap) bad = 1;
        if (!bad) begin
            ref_board[dc * 8 + dr] = mk(promo ? QUEEN : src.ptype, dc, dr, src.color);
            exp_wr_q.push_back({6'(dc * 8 + dr), ref_board[dc * 8 + dr]});
            ref_board[sc * 8 + sr] = mk(EMPTY, sc, sr, 1'b0);
            exp_wr_q.push_back({6'(sc * 8 + sr), ref_board[sc * 8 + sr]});
            if (castle) begin
                ref_board[rdc * 8 + sr] = mk(ROOK, rdc, sr, ref_turn);
                exp_wr_q.push_back({6'(rdc * 8 + sr), ref_board[rdc * 8 + sr]});
                ref_board[rc * 8 + sr] = mk(EMPTY, rc, sr, 1'b0);
                exp_wr_q.push_back({6'(rc * 8 + sr), ref_board[rc * 8 + sr]});
            end
            ref_turn = ~ref_turn;
        end
        e.err  = bad;
        e.capv = cap && !bad;
        e.cap  = dst;
        e.turn = ref_turn;
        e.lat  = castle ? (bad ? 4'd5 : 4'd9) : (bad ? 4'd4 : 4'd6);
        exp_done_q.push_back(e);
    endtask

    // ---------------- driver ----------------
    task automatic issue_move(input logic [15:0] mv);
        int k;
        k = 0;
        while (bus.move_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) check("ready_timeout", 32'd1, 32'd0);
        model_move(mv);
        bus.move       = mv;
        bus.move_valid = 1'b1;
        acc_cyc        = cyc;
        @(negedge clk);
        bus.move_valid = 1'b0;
        bus.move       = 16'($urandom);
    endtask

    task automatic run_move(input logic [15:0] mv);
        int k, start_done;
        start_done = done_seen;
        issue_move(mv);
        k = 0;
        while (done_seen == start_done && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (k >= 30) check("done_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ref_turn = WHITE;
        check("rst_ready", 32'(bus.move_ready), 32'd1);
        check("rst_turn", 32'(turn), 32'(WHITE));
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_done", 32'(done), 32'd0);
        check("rst_strobes", 32'({bus.brd_rd_en, bus.brd_wr_en}), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [9:0]  saved;
        logic [15:0] mv;
        int          k, kind, row, side, dc, sidx, didx, cand;
        bit          occ, cap, promo, inv;

        rst = 1'b1;
        load_req = 1'b0;
        bus.move_valid = 1'b0;
        bus.move = 16'd0;
        ref_turn = WHITE;
        repeat (3) @(negedge clk);
        check("reset_error", 32'(error), 32'd0);
        check("reset_cap_valid", 32'(cap_valid), 32'd0);
        check("reset_cap_piece", 32'(cap_piece), 32'd0);
        check("reset_wr_data", 32'(bus.brd_wr_data), 32'd0);
        check("reset_addr", 32'(bus.brd_addr), 32'd0);
        do_reset();
        mon_en = 1'b1;

        // Pawn push e2-e4 from the start position.
        start_position(); load_board();
        run_move(16'h0863);
        check("push_turn_black", 32'(turn), 32'(BLACK));

        // Black promotion a2-a1.
        clear_board(); put(0, 1, PAWN, BLACK); load_board();
        run_move(16'h2040);

        // White rook takes black knight.
        clear_board(); put(0, 0, ROOK, WHITE); put(0, 6, KNIGHT, BLACK); load_board();
        run_move(16'h1006);

        // Kingside castle.
        do_reset();
        clear_board(); put(4, 0, KING, WHITE); put(7, 0, ROOK, WHITE); load_board();
        run_move(16'h4830);

        // Error: reserved bit set.
        do_reset();
        start_position(); load_board();
        run_move(16'h8863);
        // Error: source is the wrong colour.
        start_position(); put(4, 1, PAWN, BLACK); load_board();
        run_move(16'h0863);
        check("err_turn_white", 32'(turn), 32'(WHITE));

        // Reset during WR_DST: destination lands, source clear never happens.
        start_position(); load_board();
        saved = ref_board[4 * 8 + 1];
        issue_move(16'h0863);
        k = 0;
        while (bus.brd_wr_en !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("wr_dst_reached", 32'(bus.brd_wr_en), 32'd1);
        do_reset();
        ref_board[4 * 8 + 1] = saved;
        repeat (4) @(negedge clk);
        check("no_write_after_reset", 32'(exp_wr_q.size()), 32'd1);
        check("no_done_after_reset", 32'(exp_done_q.size()), 32'd1);
        check("no_read_after_reset", 32'(exp_rd_q.size()), 32'd0);
        exp_wr_q.delete();
        exp_done_q.delete();
        exp_rd_q.delete();
        for (int i = 0; i < 64; i++) check("board_after_reset", 32'(mem[i]), 32'(ref_board[i]));

        // Randomised moves on random boards.
        for (int t = 0; t < 250; t++) begin
            random_board();
            kind = $urandom_range(0, 7);
            if (kind == 0) begin
                row = ref_turn ? 7 : 0;
                if ($urandom_range(0, 3) == 0) row = $urandom_range(0, 7);
                side = $urandom_range(0, 1);
                dc = side ? 6 : 2;
                put(4, row, ($urandom_range(0, 5) == 0) ? QUEEN : KING,
                    ($urandom_range(0, 5) == 0) ? ~ref_turn : ref_turn);
                put(side ? 7 : 0, row, ($urandom_range(0, 5) == 0) ? BISHOP : ROOK,
                    ($urandom_range(0, 5) == 0) ? ~ref_turn : ref_turn);
                if ($urandom_range(0, 5) != 0) put(dc, row, EMPTY, 1'b0);
                if ($urandom_range(0, 5) != 0) put(side ? 5 : 3, row, EMPTY, 1'b0);
                mv = mkmv(0, 1, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, 4, row, dc, row);
            end else begin
                sidx = $urandom_range(0, 63);
                if ($urandom_range(0, 9) != 0) begin
                    for (int j = 0; j < 40; j++) begin
                        cand = $urandom_range(0, 63);
                        if (init_board[cand][9:7] != EMPTY && init_board[cand][9:7] != INVALID &&
                            init_board[cand][0] == ref_turn) begin
                            sidx = cand;
                            break;
                        end
                    end
                end
                didx  = $urandom_range(0, 63);
                occ   = (init_board[didx][9:7] != EMPTY);
                cap   = ($urandom_range(0, 9) == 0) ? !occ : occ;
                promo = ($urandom_range(0, 9) == 0);
                inv   = ($urandom_range(0, 24) == 0);
                mv = {inv, 1'b0, promo, cap, 6'(sidx), 6'(didx)};
            end
            load_board();
            run_move(mv);
        end

        check("final_rd_q_empty", 32'(exp_rd_q.size()), 32'd0);
        check("final_wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
        check("final_done_q_empty", 32'(exp_done_q.size()), 32'd0);
        for (int i = 0; i < 64; i++) check("final_board", 32'(mem[i]), 32'(ref_board[i]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
